fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the FIFO write-address/full-check stage between NREQ requesters. Selects one requester at a time, forwards its data as a registered write strobe and word, and stalls while the FIFO signals almost-full or full. Sits in the write clock domain, directly upstream of the write-pointer logic.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATAWIDTH, 8, data word width
- BURST_LEN, 4, max beats per grant when bursting is compiled in (1..15)

- wclk  in  1  write clock, all logic on posedge
- w_rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester write request, level, held until served
- wdata_in  in  NREQ*DATAWIDTH  requester i data at bits [i*DATAWIDTH +: DATAWIDTH]
- afull  in  1  FIFO almost-full, from write-pointer stage
- Full  in  1  FIFO full, from write-pointer stage
- gnt  out  NREQ  registered one-hot grant, all-zero when idle
- ack  out  NREQ  combinational beat accept: gnt[i] & req[i] & !stall
- WE_  out  1  registered write strobe to FIFO (active-high)
- wdata  out  DATAWIDTH  registered write word, valid when WE_=1
- busy  out  1  registered, 1 when state is not IDLE

## Operation
- stall = afull | Full.
- Beat accepted in cycle N when ack[i]=1; requester presents next word (or drops req) in N+1.
- FSM states: IDLE, GRANT, STALL.
- IDLE: gnt=0. If any req=1 at edge, load gnt with round-robin winner, beat_cnt=0, go GRANT.
- Round-robin: search starts at last_gnt+1 mod NREQ, wrapping; last_gnt updated on every new grant. Reset value last_gnt=NREQ-1 (requester 0 wins first).
- GRANT: each accepted beat increments beat_cnt. Release when req[i]=0, or grant beat limit reached (1 beat without burst; BURST_LEN with burst). On release: if any req pending (including current holder), re-arbitrate into GRANT same edge (no idle bubble; holder is lowest priority); else IDLE, gnt=0.
- GRANT with stall=1: no accept, go STALL; gnt, beat_cnt held.
- STALL: on stall=0 return to GRANT. If req[i] drops in STALL, release as above.
- beat_cnt width $clog2(BURST_LEN+1); never exceeds limit; cleared on every new grant.
- Only one bit of gnt ever set; requesters without grant never get ack.

## Timing
- Reset values: gnt=0, WE_=0, wdata=0, busy=0, state IDLE, beat_cnt=0, last_gnt=NREQ-1.
- req→gnt: 1 cycle from IDLE. Back-to-back grants between requesters: 0 bubble.
- Accept→write: beat accepted in cycle N appears on WE_/wdata in N+1 for exactly one cycle; WE_=0 in any cycle following no accept.
- Throughput: 1 word/cycle while granted, req held and stall=0.
- afull must assert with at least 1 free slot, since one accepted beat can still be in flight when stall rises.
- stall rising in cycle N blocks accept in N (ack is combinational on stall).
- Reset mid-operation: in-flight beat discarded (WE_=0 cycle after reset), grant dropped, arbitration restarts at requester 0.
- Simultaneous release and stall: release wins (no beat accepted, re-arbitration proceeds).

## Configuration
- FIFO_ARB_BURST_EN defined: a grant holds up to BURST_LEN accepted beats while req stays high.
- Undefined: every grant ends after one accepted beat; BURST_LEN and beat_cnt compare unused; pure per-word round robin.

## Test plan
- Reset then req=4'b0001 held, 3 words 0xA1..0xA3 -> gnt=0001 one cycle later, WE_=1 with 0xA1,0xA2,0xA3 on consecutive cycles, then IDLE, busy=0.
- req=4'b1111 held, burst off -> gnt sequence 0001,0010,0100,1000,0001 each one cycle, WE_ every cycle, no bubble.
- req=4'b0101 held, burst on BURST_LEN=4 -> requester 0 gets 4 writes, then requester 2 gets 4, alternating; beat_cnt never exceeds 4.
- Granted requester 1, afull=1 for 3 cycles mid-burst -> ack=0 and WE_=0 during stall (after in-flight beat), gnt stays 0010, writes resume immediately when afull=0.
- Full=1 at grant time -> STALL entered, zero writes until Full=0.
- w_rst pulsed one cycle during active burst -> next cycle WE_=0, gnt=0; with req=4'b1010 afterwards, requester 1 granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters/FIFO status (master side) and the
// round-robin write arbiter (slave side).
interface fifo_wr_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 8
);
  logic [NREQ-1:0]           req;
  logic [NREQ*DATAWIDTH-1:0] wdata_in;
  logic                      afull;
  logic                      Full;
  logic [NREQ-1:0]           gnt;
  logic [NREQ-1:0]           ack;
  logic                      WE_;
  logic [DATAWIDTH-1:0]      wdata;
  logic                      busy;

  modport master (
    output req, wdata_in, afull, Full,
    input  gnt, ack, WE_, wdata, busy
  );

  modport slave (
    input  req, wdata_in, afull, Full,
    output gnt, ack, WE_, wdata, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ requesters.
// Accepted beats are forwarded one cycle later as a registered WE_/wdata pair;
// acceptance is blocked while the FIFO reports almost-full or full.
// Optional feature macro: FIFO_ARB_BURST_EN (grant holds up to BURST_LEN beats);
// without it every grant ends after a single accepted beat.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              wclk,
  input  logic              w_rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_LEN + 1);

`ifdef FIFO_ARB_BURST_EN
  localparam logic [CW-1:0] LIMIT = CW'(BURST_LEN);
`else
  localparam logic [CW-1:0] LIMIT = CW'(1);
`endif

  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

  state_t                r_state;
  state_t                w_stateNxt;
  logic [NREQ-1:0]       r_gnt;
  logic [IW-1:0]         r_lastGnt;
  logic [CW-1:0]         r_beatCnt;
  logic                  r_we;
  logic [DATAWIDTH-1:0]  r_wdata;

  logic                  w_stall;
  logic [NREQ-1:0]       w_ack;
  logic                  w_accept;
  logic                  w_lastBeat;
  logic                  w_release;
  logic                  w_anyReq;
  logic                  w_newGrant;
  logic                  w_goIdle;
  logic [IW-1:0]         w_winIdx;
  logic [DATAWIDTH-1:0]  w_words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign w_words[g] = bus.wdata_in[g*DATAWIDTH +: DATAWIDTH];
  end

  // r_lastGnt doubles as the index of the current holder while a grant is live
  assign w_stall    = bus.afull | bus.Full;
  assign w_ack      = r_gnt & bus.req & {NREQ{~w_stall}};
  assign w_accept   = |w_ack;
  assign w_lastBeat = (r_beatCnt + CW'(1)) == LIMIT;
  assign w_release  = ~bus.req[r_lastGnt] | (w_accept & w_lastBeat);
  assign w_anyReq   = |bus.req;

  // Rotating search starting just after the last winner, so the holder ranks lowest
  always_comb begin : rrSearch
    logic          found;
    logic [IW-1:0] cand;
    found    = 1'b0;
    cand     = '0;
    w_winIdx = r_lastGnt;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(r_lastGnt) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found    = 1'b1;
        w_winIdx = cand;
      end
    end
  end

  // Next-state decode; a release re-arbitrates on the same edge to avoid bubbles
  always_comb begin
    w_stateNxt = r_state;
    w_newGrant = 1'b0;
    w_goIdle   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_newGrant = 1'b1;
          w_stateNxt = GRANT;
        end
      end
      GRANT, STALL: begin
        if (w_release) begin
          if (w_anyReq) begin
            w_newGrant = 1'b1;
            w_stateNxt = GRANT;
          end else begin
            w_goIdle   = 1'b1;
            w_stateNxt = IDLE;
          end
        end else if (w_stall) begin
          w_stateNxt = STALL;
        end else begin
          w_stateNxt = GRANT;
        end
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wclk) begin
    if (w_rst) r_state <= IDLE;
    else       r_state <= w_stateNxt;
  end

  // Grant, last-winner and beat counter bookkeeping
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      r_gnt     <= '0;
      r_lastGnt <= IW'(NREQ - 1);
      r_beatCnt <= '0;
    end else if (w_newGrant) begin
      r_gnt     <= NREQ'(1) << w_winIdx;
      r_lastGnt <= w_winIdx;
      r_beatCnt <= '0;
    end else if (w_goIdle) begin
      r_gnt     <= '0;
      r_beatCnt <= '0;
    end else if (w_accept) begin
      r_beatCnt <= r_beatCnt + CW'(1);
    end
  end

  // Registered write strobe and word; strobe lasts exactly one cycle per accept
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept;
      if (w_accept) r_wdata <= w_words[r_lastGnt];
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.ack   = w_ack;
  assign bus.WE_   = r_we;
  assign bus.wdata = r_wdata;
  assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Requesters are modelled as word
// budgets; a transaction-level model predicts ack, grant, writes and busy.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int BURST_LEN = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int LIMIT = BURST_LEN;
`else
  localparam int LIMIT = 1;
`endif

  logic wclk  = 1'b0;
  logic w_rst = 1'b1;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATAWIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .BURST_LEN(BURST_LEN)) dut (
    .wclk  (wclk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  // Free-running write clock
  always #5 wclk = ~wclk;

  int checks = 0;
  int fails  = 0;

  int               holder;
  int               lastWin;
  int               beats;
  int               budget [NREQ];
  logic [DW-1:0]    word   [NREQ];
  logic [NREQ-1:0]  expAck;
  logic [NREQ-1:0]  expGnt;
  logic             expWe;
  logic [DW-1:0]    expWdata;
  logic             expBusy;
  int               dutWrites;

  function automatic logic [NREQ-1:0] pending();
    logic [NREQ-1:0] p;
    for (int i = 0; i < NREQ; i++) p[i] = (budget[i] > 0);
    return p;
  endfunction

  function automatic int rrPick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Apply requester state and FIFO status, and predict the combinational ack
  task automatic applyStimulus(input logic a, input logic f, input logic rst);
    logic [NREQ-1:0] r;
    r = pending();
    bus.req   = r;
    for (int i = 0; i < NREQ; i++) bus.wdata_in[i*DW +: DW] = word[i];
    bus.afull = a;
    bus.Full  = f;
    w_rst     = rst;
    if (holder >= 0 && r[holder] && !(a | f)) expAck = NREQ'(1) << holder;
    else                                      expAck = '0;
    #1;
  endtask

  // Advance the model across one clock edge, then wait past that edge
  task automatic modelEdge(input logic rst);
    logic [NREQ-1:0] r;
    r = pending();
    if (rst) begin
      holder   = -1;
      lastWin  = NREQ - 1;
      beats    = 0;
      expWe    = 1'b0;
      expWdata = '0;
    end else begin
      expWe = (expAck != '0);
      if (expWe) begin
        expWdata     = word[holder];
        word[holder] = word[holder] + 8'd1;
        budget[holder]--;
        beats++;
      end
      if (holder < 0) begin
        if (|r) begin
          holder  = rrPick(lastWin, r);
          lastWin = holder;
          beats   = 0;
        end
      end else if (!r[holder] || beats >= LIMIT) begin
        if (|r) begin
          holder  = rrPick(lastWin, r);
          lastWin = holder;
          beats   = 0;
        end else begin
          holder = -1;
        end
      end
    end
    expGnt  = (holder >= 0) ? (NREQ'(1) << holder) : '0;
    expBusy = (holder >= 0);
    @(posedge wclk);
    #1;
    if (bus.WE_ === 1'b1) dutWrites++;
  endtask

  task automatic clearRequesters();
    for (int i = 0; i < NREQ; i++) begin
      budget[i] = 0;
      word[i]   = '0;
    end
    dutWrites = 0;
  endtask

  task automatic test_reset();
    clearRequesters();
    holder = -1; lastWin = NREQ - 1; beats = 0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    modelEdge(1'b1);
    if (bus.gnt !== 4'b0000) begin fails++; $display("[TB] FAIL reset_gnt got=%b want=0000", bus.gnt); end
    if (bus.WE_ !== 1'b0)    begin fails++; $display("[TB] FAIL reset_we got=%b want=0", bus.WE_); end
    if (bus.wdata !== 8'h00) begin fails++; $display("[TB] FAIL reset_wdata got=%h want=00", bus.wdata); end
    if (bus.busy !== 1'b0)   begin fails++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.ack !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ack got=%b want=0000", bus.ack); end
    checks += 5;
    @(negedge wclk);
  endtask

  task automatic test_single_requester();
    clearRequesters();
    budget[0] = 3;
    word[0]   = 8'hA1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b0, c == 0);
      if (bus.ack !== expAck) begin fails++; $display("[TB] FAIL single_ack c=%0d got=%b want=%b", c, bus.ack, expAck); end
      modelEdge(c == 0);
      if (bus.gnt !== expGnt)     begin fails++; $display("[TB] FAIL single_gnt c=%0d got=%b want=%b", c, bus.gnt, expGnt); end
      if (bus.WE_ !== expWe)      begin fails++; $display("[TB] FAIL single_we c=%0d got=%b want=%b", c, bus.WE_, expWe); end
      if (bus.wdata !== expWdata) begin fails++; $display("[TB] FAIL single_wdata c=%0d got=%h want=%h", c, bus.wdata, expWdata); end
      if (bus.busy !== expBusy)   begin fails++; $display("[TB] FAIL single_busy c=%0d got=%b want=%b", c, bus.busy, expBusy); end
      checks += 5;
      if (c == 1) begin
        if (bus.gnt !== 4'b0001) begin fails++; $display("[TB] FAIL single_first_gnt got=%b want=0001", bus.gnt); end
        checks++;
      end
      @(negedge wclk);
    end
    if (dutWrites !== 3) begin fails++; $display("[TB] FAIL single_write_count got=%0d want=3", dutWrites); end
    if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL single_final_busy got=%b want=0", bus.busy); end
    checks += 2;
  endtask

  task automatic test_round_robin();
    clearRequesters();
    for (int i = 0; i < NREQ; i++) begin
      budget[i] = 5;
      word[i]   = 8'(i * 16);
    end
    for (int c = 0; c < 14; c++) begin
      applyStimulus(1'b0, 1'b0, c == 0);
      if (bus.ack !== expAck) begin fails++; $display("[TB] FAIL rr_ack c=%0d got=%b want=%b", c, bus.ack, expAck); end
      modelEdge(c == 0);
      if (bus.gnt !== expGnt)     begin fails++; $display("[TB] FAIL rr_gnt c=%0d got=%b want=%b", c, bus.gnt, expGnt); end
      if (bus.WE_ !== expWe)      begin fails++; $display("[TB] FAIL rr_we c=%0d got=%b want=%b", c, bus.WE_, expWe); end
      if (bus.wdata !== expWdata) begin fails++; $display("[TB] FAIL rr_wdata c=%0d got=%h want=%h", c, bus.wdata, expWdata); end
      if (bus.busy !== expBusy)   begin fails++; $display("[TB] FAIL rr_busy c=%0d got=%b want=%b", c, bus.busy, expBusy); end
      checks += 5;
      @(negedge wclk);
    end
    if (dutWrites !== 12) begin fails++; $display("[TB] FAIL rr_write_count got=%0d want=12", dutWrites); end
    checks++;
  endtask

  task automatic test_burst_pair();
    clearRequesters();
    budget[0] = 9; word[0] = 8'h00;
    budget[2] = 9; word[2] = 8'h20;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b0, 1'b0, c == 0);
      if (bus.ack !== expAck) begin fails++; $display("[TB] FAIL burst_ack c=%0d got=%b want=%b", c, bus.ack, expAck); end
      modelEdge(c == 0);
      if (bus.gnt !== expGnt)     begin fails++; $display("[TB] FAIL burst_gnt c=%0d got=%b want=%b", c, bus.gnt, expGnt); end
      if (bus.WE_ !== expWe)      begin fails++; $display("[TB] FAIL burst_we c=%0d got=%b want=%b", c, bus.WE_, expWe); end
      if (bus.wdata !== expWdata) begin fails++; $display("[TB] FAIL burst_wdata c=%0d got=%h want=%h", c, bus.wdata, expWdata); end
      if (bus.busy !== expBusy)   begin fails++; $display("[TB] FAIL burst_busy c=%0d got=%b want=%b", c, bus.busy, expBusy); end
      checks += 5;
      @(negedge wclk);
    end
  endtask

  task automatic test_stall_afull();
    clearRequesters();
    budget[1] = 8; word[1] = 8'h50;
    for (int c = 0; c < 14; c++) begin
      applyStimulus(c >= 4 && c < 7, 1'b0, c == 0);
      if (bus.ack !== expAck) begin fails++; $display("[TB] FAIL afull_ack c=%0d got=%b want=%b", c, bus.ack, expAck); end
      modelEdge(c == 0);
      if (bus.gnt !== expGnt)     begin fails++; $display("[TB] FAIL afull_gnt c=%0d got=%b want=%b", c, bus.gnt, expGnt); end
      if (bus.WE_ !== expWe)      begin fails++; $display("[TB] FAIL afull_we c=%0d got=%b want=%b", c, bus.WE_, expWe); end
      if (bus.wdata !== expWdata) begin fails++; $display("[TB] FAIL afull_wdata c=%0d got=%h want=%h", c, bus.wdata, expWdata); end
      if (bus.busy !== expBusy)   begin fails++; $display("[TB] FAIL afull_busy c=%0d got=%b want=%b", c, bus.busy, expBusy); end
      checks += 5;
      @(negedge wclk);
    end
  endtask

  task automatic test_full_at_grant();
    clearRequesters();
    budget[2] = 3; word[2] = 8'hC0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, c >= 1 && c < 5, c == 0);
      if (bus.ack !== expAck) begin fails++; $display("[TB] FAIL full_ack c=%0d got=%b want=%b", c, bus.ack, expAck); end
      modelEdge(c == 0);
      if (bus.gnt !== expGnt)     begin fails++; $display("[TB] FAIL full_gnt c=%0d got=%b want=%b", c, bus.gnt, expGnt); end
      if (bus.WE_ !== expWe)      begin fails++; $display("[TB] FAIL full_we c=%0d got=%b want=%b", c, bus.WE_, expWe); end
      if (bus.wdata !== expWdata) begin fails++; $display("[TB] FAIL full_wdata c=%0d got=%h want=%h", c, bus.wdata, expWdata); end
      if (bus.busy !== expBusy)   begin fails++; $display("[TB] FAIL full_busy c=%0d got=%b want=%b", c, bus.busy, expBusy); end
      checks += 5;
      @(negedge wclk);
    end
  endtask

  task automatic test_reset_midburst();
    clearRequesters();
    for (int i = 0; i < NREQ; i++) begin
      budget[i] = 6;
      word[i]   = 8'(8'h80 + i * 16);
    end
    for (int c = 0; c < 12; c++) begin
      if (c == 5) begin
        budget[0] = 0; budget[2] = 0;
        budget[1] = 3; budget[3] = 3;
      end
      applyStimulus(1'b0, 1'b0, c == 0 || c == 4);
      if (bus.ack !== expAck) begin fails++; $display("[TB] FAIL rstmid_ack c=%0d got=%b want=%b", c, bus.ack, expAck); end
      modelEdge(c == 0 || c == 4);
      if (bus.gnt !== expGnt)     begin fails++; $display("[TB] FAIL rstmid_gnt c=%0d got=%b want=%b", c, bus.gnt, expGnt); end
      if (bus.WE_ !== expWe)      begin fails++; $display("[TB] FAIL rstmid_we c=%0d got=%b want=%b", c, bus.WE_, expWe); end
      if (bus.wdata !== expWdata) begin fails++; $display("[TB] FAIL rstmid_wdata c=%0d got=%h want=%h", c, bus.wdata, expWdata); end
      if (bus.busy !== expBusy)   begin fails++; $display("[TB] FAIL rstmid_busy c=%0d got=%b want=%b", c, bus.busy, expBusy); end
      checks += 5;
      if (c == 5) begin
        if (bus.gnt !== 4'b0010) begin fails++; $display("[TB] FAIL rstmid_first_gnt got=%b want=0010", bus.gnt); end
        checks++;
      end
      @(negedge wclk);
    end
  endtask

  task automatic test_random();
    logic a, f, rst;
    clearRequesters();
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (budget[i] == 0 && $urandom_range(0, 3) == 0) begin
          budget[i] = $urandom_range(1, 6);
          word[i]   = 8'($urandom);
        end
      end
      a   = ($urandom_range(0, 9) < 2);
      f   = ($urandom_range(0, 9) < 1);
      rst = (c == 0) || ($urandom_range(0, 49) == 0);
      applyStimulus(a, f, rst);
      if (bus.ack !== expAck) begin fails++; $display("[TB] FAIL rand_ack c=%0d got=%b want=%b", c, bus.ack, expAck); end
      modelEdge(rst);
      if (bus.gnt !== expGnt)     begin fails++; $display("[TB] FAIL rand_gnt c=%0d got=%b want=%b", c, bus.gnt, expGnt); end
      if (bus.WE_ !== expWe)      begin fails++; $display("[TB] FAIL rand_we c=%0d got=%b want=%b", c, bus.WE_, expWe); end
      if (bus.wdata !== expWdata) begin fails++; $display("[TB] FAIL rand_wdata c=%0d got=%h want=%h", c, bus.wdata, expWdata); end
      if (bus.busy !== expBusy)   begin fails++; $display("[TB] FAIL rand_busy c=%0d got=%b want=%b", c, bus.busy, expBusy); end
      checks += 5;
      @(negedge wclk);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    holder   = -1;
    lastWin  = NREQ - 1;
    beats    = 0;
    expAck   = '0;
    expGnt   = '0;
    expWe    = 1'b0;
    expWdata = '0;
    expBusy  = 1'b0;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_burst_pair();
    test_stall_afull();
    test_full_at_grant();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
